// File: rtl/maze_pkg.sv
// Shared maze-control definitions: direction codes, move FSM states and the
// button-to-direction decoder.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] dir;
  } dir_dec_t;

  // Exactly one pressed button is a direction; anything else means "none".
  function automatic dir_dec_t decode_btn(input logic [3:0] b);
    dir_dec_t d;
    d.valid = 1'b1;
    d.dir   = DIR_UP;
    case (b)
      4'b0001: d.dir = DIR_UP;
      4'b0010: d.dir = DIR_DOWN;
      4'b0100: d.dir = DIR_LEFT;
      4'b1000: d.dir = DIR_RIGHT;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Turns every transition of the divider's toggle signal into a one-cycle,
// registered tick pulse.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_out
);

  logic r_tick_d;
  logic r_tick_out;

  // tick_d follows tick_in even in reset so the first cycle after reset is quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_d   <= tick_in;
      r_tick_out <= 1'b0;
    end else begin
      r_tick_d   <= tick_in;
      r_tick_out <= tick_in ^ r_tick_d;
    end
  end

  assign tick_out = r_tick_out;

endmodule

// File: rtl/move_repeat_ctrl.sv
// Debounces the four direction buttons on 100 ms ticks and issues maze moves
// with keyboard-style auto-repeat over a valid/ready handshake.
module move_repeat_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned DEB_SAMPLES  = 2,
  parameter int unsigned DELAY_TICKS  = 3,
  parameter int unsigned REPEAT_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [3:0] btn,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       tick_out
);

  localparam logic [2:0] DEB_N = 3'(DEB_SAMPLES);
  localparam logic [3:0] DLY_N = 4'(DELAY_TICKS);
  localparam logic [3:0] RPT_N = 4'(REPEAT_TICKS);

  logic       w_tick;
  logic [3:0] r_last;
  logic [2:0] r_same;
  logic [3:0] r_deb;
  logic [2:0] w_same_next;
  logic [3:0] w_deb_next;
  dir_dec_t   w_dec;

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [1:0] r_cur_dir, w_cur_next;
  logic       w_issue;
  logic [1:0] w_issue_dir;

  logic       r_valid;
  logic [1:0] r_dir;
  logic       w_accept;

  tick_edge_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .tick_out (w_tick)
  );

  // Debounced value is computed combinationally on the tick so the FSM can
  // act on the very tick that completes debounce.
  always_comb begin
    w_same_next = 3'd1;
    if (r_same != 3'd0 && btn == r_last)
      w_same_next = (r_same >= DEB_N) ? r_same : r_same + 3'd1;
    w_deb_next = (w_same_next >= DEB_N) ? btn : r_deb;
    w_dec      = decode_btn(w_deb_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
      r_same <= '0;
      r_deb  <= '0;
    end else if (w_tick) begin
      r_last <= btn;
      r_same <= w_same_next;
      r_deb  <= w_deb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cur_dir <= DIR_UP;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_cur_dir <= w_cur_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cur_next   = r_cur_dir;
    w_issue      = 1'b0;
    w_issue_dir  = r_cur_dir;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_dec.valid) begin
            w_issue      = 1'b1;
            w_issue_dir  = w_dec.dir;
            w_cur_next   = w_dec.dir;
            w_cnt_next   = DLY_N;
            w_state_next = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!w_dec.valid) begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else if (w_dec.dir != r_cur_dir) begin
            w_issue      = 1'b1;
            w_issue_dir  = w_dec.dir;
            w_cur_next   = w_dec.dir;
            w_cnt_next   = DLY_N;
            w_state_next = DELAY;
          end else if (r_cnt <= 4'd1) begin
            w_issue      = 1'b1;
            w_cnt_next   = RPT_N;
            w_state_next = REPEAT;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        default: begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign w_accept = r_valid & move_ready;

  // A new move only lands in an empty slot or one being emptied this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_dir   <= DIR_UP;
    end else if (w_issue && (!r_valid || w_accept)) begin
      r_valid <= 1'b1;
      r_dir   <= w_issue_dir;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign move_valid = r_valid;
  assign move_dir   = r_dir;
  assign tick_out   = w_tick;

endmodule

// File: tb/tb_move_repeat_ctrl.sv
// Bench for move_repeat_ctrl: scenario table, hand-written corner sequences and
// randomized traffic, all checked every cycle against a behavioural model.
module tb_move_repeat_ctrl;

  localparam int DEB = 2;
  localparam int DLY = 3;
  localparam int RPT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic [3:0] btn;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       tick_out;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit tog_en = 1'b0;
  int tog_cnt = 0;

  move_repeat_ctrl #(
    .DEB_SAMPLES  (DEB),
    .DELAY_TICKS  (DLY),
    .REPEAT_TICKS (RPT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .btn        (btn),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .tick_out   (tick_out)
  );

  always #5 clk = ~clk;

  // Reference model: sample history, held direction, ticks since last move.
  logic [3:0] m_hist[$];
  logic [3:0] m_deb = '0;
  int         m_held = -1;
  int         m_nissued = 0;
  int         m_since = 0;
  bit         m_valid = 1'b0;
  logic [1:0] m_dir = '0;
  bit         m_tick = 1'b0;
  bit         m_prev = 1'b0;

  function automatic int dir_of(input logic [3:0] b);
    case (b)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_update();
    bit accept, issue, same;
    int d, idir, lim;
    if (rst) begin
      m_hist.delete();
      m_deb = '0; m_held = -1; m_nissued = 0; m_since = 0;
      m_valid = 1'b0; m_dir = '0; m_tick = 1'b0; m_prev = tick_in;
      return;
    end
    accept = m_valid && move_ready;
    issue = 1'b0; idir = 0;
    if (m_tick) begin
      m_hist.push_back(btn);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      if (m_hist.size() == DEB) begin
        same = 1'b1;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) same = 1'b0;
        if (same) m_deb = m_hist[0];
      end
      d = dir_of(m_deb);
      if (d < 0) m_held = -1;
      else if (d != m_held) begin
        m_held = d; m_nissued = 1; m_since = 0; issue = 1'b1; idir = d;
      end else begin
        m_since++;
        lim = (m_nissued == 1) ? DLY : RPT;
        if (m_since == lim) begin
          issue = 1'b1; idir = d; m_nissued++; m_since = 0;
        end
      end
    end
    if (issue && (!m_valid || accept)) begin
      m_valid = 1'b1; m_dir = 2'(idir);
    end else if (accept) m_valid = 1'b0;
    m_tick = (tick_in != m_prev);
    m_prev = tick_in;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    if (tog_en) begin
      if (tog_cnt == 9) begin tick_in = ~tick_in; tog_cnt = 0; end
      else tog_cnt++;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    chk("tick_out", 32'(tick_out), 32'(m_tick));
    chk("move_valid", 32'(move_valid), 32'(m_valid));
    chk("move_dir", 32'(move_dir), 32'(m_dir));
  endtask

  task automatic apply_reset();
    rst = 1'b1; tog_en = 1'b0; tog_cnt = 0;
    step(); step();
    rst = 1'b0; cyc = 0; tog_en = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn;
    int         ticks;
    int         exp_moves;
    int         exp_dir;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nmoves, last_dir, viol, found, k;
    int rec_cyc[$];
    int rec_dir[$];

    vecs[0] = '{4'b0001, 1, 0, 0};
    vecs[1] = '{4'b0001, 2, 1, 0};
    vecs[2] = '{4'b0001, 4, 1, 0};
    vecs[3] = '{4'b0001, 5, 2, 0};
    vecs[4] = '{4'b1000, 7, 4, 3};
    vecs[5] = '{4'b0101, 6, 0, 0};
    vecs[6] = '{4'b0000, 6, 0, 0};
    vecs[7] = '{4'b0100, 10, 7, 2};
    vecs[8] = '{4'b0010, 3, 1, 1};
    vecs[9] = '{4'b1111, 5, 0, 0};

    rst = 1'b1; tick_in = 1'b1; btn = 4'b0001; move_ready = 1'b1;
    @(negedge clk);

    // Reset with tick_in=1 and no toggling: no tick, no move.
    apply_reset();
    tog_en = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_out || move_valid) viol++;
    end
    chk("quiet_after_reset", 32'(viol), 32'd0);

    // Scenario table: hold a pattern with ready=1 and count issued moves.
    foreach (vecs[v]) begin
      btn = vecs[v].btn; move_ready = 1'b1;
      apply_reset();
      nmoves = 0; last_dir = 0;
      for (int i = 0; i < vecs[v].ticks * 10 + 5; i++) begin
        step();
        if (move_valid) begin nmoves++; last_dir = int'(move_dir); end
      end
      chk($sformatf("vec%0d_moves", v), 32'(nmoves), 32'(vecs[v].exp_moves));
      chk($sformatf("vec%0d_dir", v), 32'(last_dir), 32'(vecs[v].exp_dir));
    end

    // Backpressure: one pending right move held stable, then accepted.
    btn = 4'b1000; move_ready = 1'b0;
    apply_reset();
    nmoves = 0; viol = 0;
    for (int i = 0; i < 95; i++) begin
      bit prev_v;
      prev_v = move_valid;
      step();
      if (move_valid && !prev_v) nmoves++;
      if (move_valid && move_dir != 2'd3) viol++;
    end
    chk("stall_rises", 32'(nmoves), 32'd1);
    chk("stall_stable", 32'(viol), 32'd0);
    chk("stall_pending", 32'(move_valid), 32'd1);
    move_ready = 1'b1;
    step();
    chk("accept_clears", 32'(move_valid), 32'd0);
    found = 0;
    for (k = 1; k <= 20; k++) begin
      step();
      if (move_valid) begin found = k; break; end
    end
    chk("next_repeat_delay", 32'(found), 32'd5);

    // Single-tick glitch: no move.
    btn = 4'b0100;
    apply_reset();
    for (int i = 0; i < 15; i++) step();
    btn = 4'b0000;
    nmoves = 0;
    for (int i = 0; i < 40; i++) begin step(); if (move_valid) nmoves++; end
    chk("glitch_no_move", 32'(nmoves), 32'd0);

    // Two buttons -> none; then a single left press debounces in 2 ticks.
    btn = 4'b0101;
    apply_reset();
    nmoves = 0;
    for (int i = 0; i < 30; i++) begin step(); if (move_valid) nmoves++; end
    chk("two_bits_no_move", 32'(nmoves), 32'd0);
    btn = 4'b0100;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (move_valid) begin found = cyc; break; end
    end
    chk("left_after_two_bits", 32'(found), 32'd41);
    chk("left_dir", 32'(move_dir), 32'd2);

    // Direction switch after the first repeat.
    btn = 4'b0001;
    apply_reset();
    for (int i = 0; i < 55; i++) step();
    btn = 4'b0010;
    for (int i = 0; i < 55; i++) begin
      step();
      if (move_valid) begin rec_cyc.push_back(cyc); rec_dir.push_back(int'(move_dir)); end
    end
    chk("switch_count", 32'(rec_cyc.size()), 32'd3);
    if (rec_cyc.size() == 3) begin
      chk("switch_up_cyc", 32'(rec_cyc[0]), 32'd61);
      chk("switch_up_dir", 32'(rec_dir[0]), 32'd0);
      chk("switch_down_cyc", 32'(rec_cyc[1]), 32'd71);
      chk("switch_down_dir", 32'(rec_dir[1]), 32'd1);
      chk("switch_next_cyc", 32'(rec_cyc[2]), 32'd101);
    end

    // Reset while a move is pending.
    btn = 4'b0100; move_ready = 1'b0;
    apply_reset();
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (move_valid) begin found = 1; break; end
    end
    chk("pending_before_reset", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("reset_clears_valid", 32'(move_valid), 32'd0);
    chk("reset_clears_dir", 32'(move_dir), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: btn = 4'(1 << $urandom_range(0, 3));
          6, 7: btn = 4'b0000;
          default: btn = 4'($urandom_range(0, 15));
        endcase
      end
      move_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
